// File: rtl/shift_rot_seq.sv
// Sequential barrel shifter/rotator: one log2 stage per cycle over a captured operand.
// Fixed latency of CNTW cycles from accept to result, with valid/ready handshakes on both sides.
module shift_rot_seq #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNTW-1:0]  in_cnt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    ModeRol = 2'b00,
    ModeSll = 2'b01,
    ModeRor = 2'b10,
    ModeSra = 2'b11
  } mode_e;

  state_e            state_q;
  mode_e             mode_q;
  logic [CNTW-1:0]   cnt_q;
  logic [CNTW-1:0]   k_q;
  logic [WIDTH-1:0]  work_q;
  logic              sign_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  logic [CNTW:0]     amt;
  logic              stage_en;
  logic [2*WIDTH-1:0] rol_ext;
  logic [2*WIDTH-1:0] ror_ext;
  logic [2*WIDTH-1:0] sra_ext;
  logic [WIDTH-1:0]  stage_d;

  // Stage k moves the working register by 2^k when bit k of the captured count is set.
  always_comb begin
    amt      = (CNTW+1)'(1) << k_q;
    stage_en = |(cnt_q & (CNTW'(1) << k_q));
    rol_ext  = {work_q, work_q} << amt;
    ror_ext  = {work_q, work_q} >> amt;
    // Fill comes from the operand's original MSB, held in sign_q.
    sra_ext  = {{WIDTH{sign_q}}, work_q} >> amt;
    stage_d  = work_q;
    unique case (mode_q)
      ModeRol: stage_d = rol_ext[2*WIDTH-1:WIDTH];
      ModeSll: stage_d = work_q << amt;
      ModeRor: stage_d = ror_ext[WIDTH-1:0];
      ModeSra: stage_d = sra_ext[WIDTH-1:0];
      default: stage_d = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mode_q      <= ModeRol;
      cnt_q       <= '0;
      k_q         <= '0;
      work_q      <= '0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StRun;
            mode_q     <= mode_e'(in_mode);
            cnt_q      <= in_cnt;
            k_q        <= '0;
            work_q     <= in_data;
            sign_q     <= in_data[WIDTH-1];
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StRun: begin
          if (stage_en) begin
            work_q <= stage_d;
          end
          k_q <= k_q + 1'b1;
          if (k_q == CNTW'(CNTW - 1)) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StIdle;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = work_q;

endmodule

// File: doc/shift_rot_seq.md
SHIFT_ROT_SEQ -- requirements
Module: shift_rot_seq

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width; SHALL be a power of two and at least 4.
REQ-002 Parameter: CNTW, default 4, shift-count width; SHALL equal log2(WIDTH).
REQ-003 Port: clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  input  1  request present.
REQ-006 Port: in_ready  output  1  block can accept a request.
REQ-007 Port: in_data  input  WIDTH  operand.
REQ-008 Port: in_cnt  input  CNTW  shift amount, 0..WIDTH-1.
REQ-009 Port: in_mode  input  2  operation: 00 ROL, 01 SLL, 10 ROR, 11 SRA.
REQ-010 Port: out_valid  output  1  result present.
REQ-011 Port: out_ready  input  1  consumer accepts result.
REQ-012 Port: out_data  output  WIDTH  result.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE, and no others.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 Accept: in IDLE with in_valid=1, capture in_data, in_cnt and in_mode, set stage index k=0, and go to RUN.
REQ-017 In IDLE with in_valid=0, the FSM SHALL stay in IDLE and hold all registers.
REQ-018 RUN SHALL execute one log-stage per cycle: if captured cnt[k]=1, the working register is shifted or rotated by 2^k per mode, else held; k then increments.
REQ-019 When k=CNTW-1 in RUN, the FSM SHALL go to DONE on that edge.
REQ-020 Latency SHALL be fixed: out_valid rises exactly CNTW cycles after the accepting edge, independent of cnt, including cnt=0.
REQ-021 ROL and ROR SHALL be circular over WIDTH bits.
REQ-022 SLL SHALL zero-fill from the LSB side.
REQ-023 SRA SHALL fill from the MSB side with the operand's original bit WIDTH-1.
REQ-024 cnt=0 SHALL return the operand unchanged in every mode.
REQ-025 In DONE, out_data SHALL remain stable while out_ready=0, and in_valid SHALL be ignored.
REQ-026 In DONE with out_ready=1, the result is consumed and the FSM SHALL go to IDLE; a new request is accepted no earlier than the following cycle.
REQ-027 in_data, in_cnt and in_mode changes while busy=1 SHALL NOT affect the operation in flight.
REQ-028 out_data SHALL be the working register; its value outside DONE is don't-care for consumers, but SHALL be deterministic.

Reset
REQ-029 rst_n=0 SHALL, asynchronously and from any state, force state=IDLE, k=0, working register=0 and mode/cnt captures=0.
REQ-030 During and after reset: out_valid=0, out_data=0, busy=0, in_ready=1 (first cycle after release).
REQ-031 An operation interrupted by reset SHALL be abandoned, with no output produced for it.
REQ-032 Release of rst_n SHALL be synchronised externally; the block needs no other initialisation.

Verification
REQ-033 Scenario: ROL 0x1234 cnt=8, out_ready=1 -> out_valid 4 cycles after accept, out_data=0x3412, then in_ready=1 next cycle.
REQ-034 Scenario: SLL 0x8001 cnt=1 -> 0x0002; ROR 0x0001 cnt=15 -> 0x0002; any mode on 0xBEEF with cnt=0 -> 0xBEEF after 4 cycles.
REQ-035 Scenario: SRA 0x8000 cnt=15 -> 0xFFFF; SRA 0x4000 cnt=14 -> 0x0001; SRA 0xF0F0 cnt=4 -> 0xFF0F.
REQ-036 Scenario: result ready with out_ready=0 for 3 cycles and in_valid=1 with new data -> out_data held at the same value, in_ready=0, new request not taken; out_ready=1 -> IDLE, then the new request is accepted.
REQ-037 Scenario: rst_n pulsed low in the 2nd RUN cycle -> immediately out_valid=0, out_data=0, busy=0; after release in_ready=1, and the next ROL 0x00FF cnt=4 -> 0x0FF0.
REQ-038 Scenario: WIDTH=32 instance, SRA 0x80000000 cnt=31 -> 0xFFFFFFFF with latency 5; ROL 0x12345678 cnt=16 -> 0x56781234.
